// File: rtl/regfile_wb_sched_if.sv
// rtl/regfile_wb_sched_if.sv - execute/decode side bus of the register file write-back scheduler
interface regfile_wb_sched_if #(
    parameter int XLEN = 32
);
    logic            alu_wr_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            mdu_wr_valid;
    logic [4:0]      mdu_rd;
    logic [XLEN-1:0] mdu_data;
    logic            mdu_wr_ready;
    logic            issue_valid;
    logic [4:0]      issue_rs1;
    logic [4:0]      issue_rs2;
    logic [4:0]      issue_rd;
    logic            issue_uses_rs1;
    logic            issue_uses_rs2;
    logic            issue_writes_rd;
    logic            issue_is_mdu;
    logic            stall;
    logic            wr_en;
    logic [4:0]      rd;
    logic [XLEN-1:0] write_data;
    logic [31:0]     pending;

    modport master (
        output alu_wr_valid, alu_rd, alu_data,
        output mdu_wr_valid, mdu_rd, mdu_data,
        output issue_valid, issue_rs1, issue_rs2, issue_rd,
        output issue_uses_rs1, issue_uses_rs2, issue_writes_rd, issue_is_mdu,
        input  mdu_wr_ready, stall, wr_en, rd, write_data, pending
    );

    modport slave (
        input  alu_wr_valid, alu_rd, alu_data,
        input  mdu_wr_valid, mdu_rd, mdu_data,
        input  issue_valid, issue_rs1, issue_rs2, issue_rd,
        input  issue_uses_rs1, issue_uses_rs2, issue_writes_rd, issue_is_mdu,
        output mdu_wr_ready, stall, wr_en, rd, write_data, pending
    );
endinterface

// File: rtl/regfile_wb_sched.sv
// rtl/regfile_wb_sched.sv - shares the regfile write port between ALU and MDU, tracks pending MDU rds
// Optional starvation guard (DRAIN state, wait_cnt) enabled by defining WB_STARVE_GUARD_EN.
module regfile_wb_sched #(
    parameter int XLEN         = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_sched_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]      fifo_rd_q   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic            wr_en_q, wr_en_d;
    logic            wr_mdu_q, wr_mdu_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] write_data_q, write_data_d;
    logic [31:0]     pending_q, pending_d;

    logic fifo_empty, mdu_wr_ready, push, pop;
    logic hazard, drain, stall, set_pend;

    assign fifo_empty   = (count_q == '0);
    assign mdu_wr_ready = (count_q < CNT_W'(FIFO_DEPTH));
    assign push         = bus.mdu_wr_valid && mdu_wr_ready;
    // ALU has strict priority; the FIFO head only gets idle ALU cycles
    assign pop          = !bus.alu_wr_valid && !fifo_empty;

`ifdef WB_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT) + 1;

    typedef enum logic {ST_NORMAL, ST_DRAIN} state_t;
    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_NORMAL: begin
                if (pop || fifo_empty) begin
                    wait_cnt_d = '0;
                end else begin
                    if (wait_cnt_q == WAIT_W'(STARVE_LIMIT - 1)) state_d = ST_DRAIN;
                    if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (pop) begin
                    wait_cnt_d = '0;
                    state_d    = ST_NORMAL;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    assign drain = (state_q == ST_DRAIN);
`else
    assign drain = 1'b0;
`endif

    always_comb begin
        hazard = (bus.issue_uses_rs1  && pending_q[bus.issue_rs1]) ||
                 (bus.issue_uses_rs2  && pending_q[bus.issue_rs2]) ||
                 (bus.issue_writes_rd && pending_q[bus.issue_rd]);
        stall  = bus.issue_valid && (hazard || drain);
    end

    always_comb begin
        wr_en_d      = 1'b0;
        wr_mdu_d     = 1'b0;
        rd_d         = '0;
        write_data_d = '0;
        if (bus.alu_wr_valid) begin
            if (bus.alu_rd != 5'd0) begin
                wr_en_d      = 1'b1;
                rd_d         = bus.alu_rd;
                write_data_d = bus.alu_data;
            end
        end else if (pop) begin
            if (fifo_rd_q[rd_ptr_q] != 5'd0) begin
                wr_en_d      = 1'b1;
                wr_mdu_d     = 1'b1;
                rd_d         = fifo_rd_q[rd_ptr_q];
                write_data_d = fifo_data_q[rd_ptr_q];
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    // Clear applies first so a re-issue to the same rd in the write-back cycle keeps the bit set
    always_comb begin
        pending_d = pending_q;
        if (wr_en_q && wr_mdu_q) pending_d[rd_q] = 1'b0;
        set_pend = bus.issue_valid && !stall && bus.issue_is_mdu &&
                   bus.issue_writes_rd && (bus.issue_rd != 5'd0);
        if (set_pend) pending_d[bus.issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wr_en_q      <= 1'b0;
            wr_mdu_q     <= 1'b0;
            rd_q         <= '0;
            write_data_q <= '0;
            pending_q    <= '0;
`ifdef WB_STARVE_GUARD_EN
            state_q      <= ST_NORMAL;
            wait_cnt_q   <= '0;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wr_en_q      <= wr_en_d;
            wr_mdu_q     <= wr_mdu_d;
            rd_q         <= rd_d;
            write_data_q <= write_data_d;
            pending_q    <= pending_d;
`ifdef WB_STARVE_GUARD_EN
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
`endif
            if (push) begin
                fifo_rd_q[wr_ptr_q]   <= bus.mdu_rd;
                fifo_data_q[wr_ptr_q] <= bus.mdu_data;
            end
        end
    end

    assign bus.mdu_wr_ready = mdu_wr_ready;
    assign bus.stall        = stall;
    assign bus.wr_en        = wr_en_q;
    assign bus.rd           = rd_q;
    assign bus.write_data   = write_data_q;
    assign bus.pending      = pending_q;
endmodule
